// File: rtl/flight_mode_sequencer_pkg.sv
// Shared codes and widths for the flight mode sequencer and its receiver data buffer.
package flight_mode_sequencer_pkg;

    localparam int REC_DATA_SEL_BIT_WIDTH = 3;
    localparam int PWM_VALUE_BIT_WIDTH    = 11;

    // Motor rate at or below this is treated as "motors stopped" while landing.
    localparam logic [PWM_VALUE_BIT_WIDTH-1:0] MOTOR_VAL_MIN = 11'd20;

    // rec_data_sel codes double as the sequencer state encoding.
    typedef enum logic [REC_DATA_SEL_BIT_WIDTH-1:0] {
        REC_SEL_OFF           = 3'd0,
        REC_SEL_AUTO_TAKE_OFF = 3'd1,
        REC_SEL_HOVER         = 3'd2,
        REC_SEL_PASS_THROUGH  = 3'd3,
        REC_SEL_AUTO_LAND     = 3'd4
    } rec_sel_e;

    // swb mode request encodings; 3 behaves as LAND.
    typedef enum logic [1:0] {
        SWB_MANUAL   = 2'd0,
        SWB_AUTO     = 2'd1,
        SWB_LAND     = 2'd2,
        SWB_LAND_ALT = 2'd3
    } swb_e;

    // Both LAND encodings share the upper bit.
    function automatic logic is_land_req(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/flight_mode_sequencer_switch_debounce.sv
// Switch debouncer: output follows the raw input only after it has held one
// value for DEBOUNCE_US consecutive cycles. Any change of the raw value restarts
// the count, so a glitch between two non-accepted values is never taken.
module switch_debounce #(
    parameter int WIDTH       = 1,
    parameter int DEBOUNCE_US = 20000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] sw_o
);
    localparam int CW = $clog2(DEBOUNCE_US + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_US);

    logic [WIDTH-1:0] out_q, out_d, cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;

    // Count consecutive cycles of the same raw value that differs from the output.
    always_comb begin
        out_d   = out_q;
        cand_d  = raw_i;
        cnt_d   = '0;
        cnt_nxt = (raw_i == cand_q) ? cnt_q + 1'b1 : CW'(1);
        if (raw_i != out_q) begin
            if (cnt_nxt == CNT_DONE) begin
                out_d = raw_i;
            end else begin
                cnt_d = cnt_nxt;
            end
        end
    end

    // Debouncer state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q  <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sw_o = out_q;

endmodule

// File: rtl/flight_mode_sequencer.sv
// Flight mode sequencer: drives rec_data_sel from debounced switches, link
// status and motor rate. Optional link-loss failsafe: FLIGHT_MODE_FAILSAFE_EN.
module flight_mode_sequencer
    import flight_mode_sequencer_pkg::*;
#(
    parameter int TAKEOFF_US       = 1500000,
    parameter int LANDED_US        = 500000,
    parameter int FAILSAFE_US      = 250000,
    parameter int DEBOUNCE_US      = 20000,
    parameter int THROTTLE_ARM_MAX = 10
) (
    input  logic                              us_clk,
    input  logic                              resetn,
    input  logic                              swa,
    input  logic [1:0]                        swb,
    input  logic                              rec_valid,
    input  logic [PWM_VALUE_BIT_WIDTH-1:0]    throttle_rec_val,
    input  logic [PWM_VALUE_BIT_WIDTH-1:0]    curr_motor_rate,
    output logic [REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel,
    output logic                              mode_change,
    output logic                              failsafe_active
);
    localparam int TKW = $clog2(TAKEOFF_US + 1);
    localparam int LDW = $clog2(LANDED_US + 1);
    localparam logic [TKW-1:0] TKO_LOAD = TKW'(TAKEOFF_US);
    localparam logic [LDW-1:0] LD_MAX   = LDW'(LANDED_US);
    localparam logic [LDW-1:0] LD_LAST  = LDW'(LANDED_US - 1);
    localparam logic [PWM_VALUE_BIT_WIDTH-1:0] THR_MAX = PWM_VALUE_BIT_WIDTH'(THROTTLE_ARM_MAX);

    rec_sel_e       state_q, state_d;
    logic           mode_change_q, mode_change_d;
    logic           armok_q, armok_d;
    logic [TKW-1:0] tko_q, tko_d;
    logic [LDW-1:0] land_q, land_d;
    logic           arm_d;
    logic [1:0]     mode_d;
    logic           fail_now;

    switch_debounce #(.WIDTH(1), .DEBOUNCE_US(DEBOUNCE_US)) u_swa_db (
        .clk(us_clk), .resetn(resetn), .raw_i(swa), .sw_o(arm_d)
    );
    switch_debounce #(.WIDTH(2), .DEBOUNCE_US(DEBOUNCE_US)) u_swb_db (
        .clk(us_clk), .resetn(resetn), .raw_i(swb), .sw_o(mode_d)
    );

`ifdef FLIGHT_MODE_FAILSAFE_EN
    localparam int FSW = $clog2(FAILSAFE_US + 1);
    localparam logic [FSW-1:0] FS_MAX = FSW'(FAILSAFE_US);
    logic [FSW-1:0] fail_cnt_q, fail_cnt_d;
    logic           fail_q;

    // Consecutive invalid-frame count, saturating at the failsafe threshold.
    always_comb begin
        fail_cnt_d = '0;
        if (!rec_valid) begin
            fail_cnt_d = (fail_cnt_q == FS_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
        end
    end

    // failsafe_active rises on the same edge the state reacts to link loss.
    assign fail_now = (fail_cnt_d == FS_MAX);

    // Link-loss counter and flag registers.
    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            fail_cnt_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            fail_q     <= fail_now;
        end
    end

    assign failsafe_active = fail_q;
`else
    logic unused_rec_valid;
    assign unused_rec_valid = rec_valid;
    assign fail_now         = 1'b0;
    assign failsafe_active  = 1'b0;
`endif

    logic rate_low, tko_expire, landed, thr_ok;
    assign rate_low   = (curr_motor_rate <= MOTOR_VAL_MIN);
    assign tko_expire = (tko_q <= TKW'(1));
    assign landed     = (state_q == REC_SEL_AUTO_LAND) && rate_low && (land_q >= LD_LAST);
    assign thr_ok     = (throttle_rec_val <= THR_MAX);

    // Next-state: kill > failsafe > landed > switch request > takeoff expiry.
    // Disarm outranks a MANUAL request in the auto states so a disarm mid-air lands
    // instead of dropping into pass-through and being killed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REC_SEL_OFF: begin
                if (arm_d && armok_q) begin
                    if (mode_d == SWB_AUTO)
                        state_d = REC_SEL_AUTO_TAKE_OFF;
                    else if (mode_d == SWB_MANUAL && thr_ok && !fail_now)
                        state_d = REC_SEL_PASS_THROUGH;
                end
            end
            REC_SEL_AUTO_TAKE_OFF: begin
                if (fail_now || !arm_d || is_land_req(mode_d))
                    state_d = REC_SEL_AUTO_LAND;
                else if (mode_d == SWB_MANUAL)
                    state_d = REC_SEL_PASS_THROUGH;
                else if (tko_expire)
                    state_d = REC_SEL_HOVER;
            end
            REC_SEL_HOVER: begin
                if (fail_now || !arm_d || is_land_req(mode_d))
                    state_d = REC_SEL_AUTO_LAND;
                else if (mode_d == SWB_MANUAL)
                    state_d = REC_SEL_PASS_THROUGH;
            end
            REC_SEL_PASS_THROUGH: begin
                if (!arm_d)
                    state_d = REC_SEL_OFF;
                else if (fail_now || is_land_req(mode_d))
                    state_d = REC_SEL_AUTO_LAND;
                else if (mode_d == SWB_AUTO)
                    state_d = REC_SEL_HOVER;
            end
            REC_SEL_AUTO_LAND: begin
                if (landed)
                    state_d = REC_SEL_OFF;
                else if (arm_d && mode_d == SWB_MANUAL && !fail_now)
                    state_d = REC_SEL_PASS_THROUGH;
            end
            default: state_d = REC_SEL_OFF;
        endcase
    end

    // Timers and the re-arm latch. A refused armed start in OFF also clears the
    // latch, so the pilot must cycle the arm switch before trying again.
    always_comb begin
        mode_change_d = (state_d != state_q);

        armok_d = armok_q;
        if (state_q != REC_SEL_OFF) begin
            if (state_d == REC_SEL_OFF) armok_d = 1'b0;
        end else if (!arm_d) begin
            armok_d = 1'b1;
        end else if (state_d == REC_SEL_OFF) begin
            armok_d = 1'b0;
        end

        tko_d = '0;
        if (state_d == REC_SEL_AUTO_TAKE_OFF) begin
            if (state_q != REC_SEL_AUTO_TAKE_OFF) tko_d = TKO_LOAD;
            else if (tko_q != '0)                 tko_d = tko_q - 1'b1;
        end

        land_d = '0;
        if (state_q == REC_SEL_AUTO_LAND && state_d == REC_SEL_AUTO_LAND && rate_low)
            land_d = (land_q == LD_MAX) ? land_q : land_q + 1'b1;
    end

    // Sequencer registers.
    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state_q       <= REC_SEL_OFF;
            mode_change_q <= 1'b0;
            armok_q       <= 1'b0;
            tko_q         <= '0;
            land_q        <= '0;
        end else begin
            state_q       <= state_d;
            mode_change_q <= mode_change_d;
            armok_q       <= armok_d;
            tko_q         <= tko_d;
            land_q        <= land_d;
        end
    end

    assign rec_data_sel = state_q;
    assign mode_change  = mode_change_q;

endmodule

// File: tb/tb_flight_mode_sequencer.sv
// Scoreboard bench for flight_mode_sequencer: the stimulus queues the expected
// rec_data_sel, failsafe flag and cycle of each mode change; a monitor pops one
// entry on every mode_change pulse.
module tb_flight_mode_sequencer;
    import flight_mode_sequencer_pkg::*;

    localparam int D   = 128;
    localparam int T   = 300;
    localparam int L   = 200;
    localparam int F   = 150;
    localparam int THR = 10;
    localparam int PW  = PWM_VALUE_BIT_WIDTH;

    logic          us_clk = 1'b0;
    logic          resetn = 1'b0;
    logic          swa = 1'b0;
    logic [1:0]    swb = 2'd0;
    logic          rec_valid = 1'b1;
    logic [PW-1:0] thr = '0;
    logic [PW-1:0] rate = '0;
    logic [REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel;
    logic          mode_change;
    logic          failsafe_active;

    flight_mode_sequencer #(
        .TAKEOFF_US(T), .LANDED_US(L), .FAILSAFE_US(F),
        .DEBOUNCE_US(D), .THROTTLE_ARM_MAX(THR)
    ) dut (
        .us_clk(us_clk), .resetn(resetn), .swa(swa), .swb(swb),
        .rec_valid(rec_valid), .throttle_rec_val(thr), .curr_motor_rate(rate),
        .rec_data_sel(rec_data_sel), .mode_change(mode_change),
        .failsafe_active(failsafe_active)
    );

    always #5 us_clk = ~us_clk;

    int cyc = 0;
    always @(posedge us_clk) cyc <= cyc + 1;

    typedef struct {
        int    sel;
        int    fs;
        int    at;
        string tag;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int sel, input int fs, input int at, input string tag);
        exp_t e;
        e.sel = sel; e.fs = fs; e.at = at; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge us_clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    // Monitor: every mode_change pulse must match the next queued expectation.
    always @(negedge us_clk) begin
        if (mode_change === 1'b1) begin : mon
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: got sel=%0d at cycle %0d expected no change",
                         rec_data_sel, cyc);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_sel"},   int'(rec_data_sel),    e.sel);
                chk({e.tag, "_fs"},    int'(failsafe_active), e.fs);
                chk({e.tag, "_cycle"}, cyc,                   e.at);
            end
        end
    end

    initial begin : stim
        int n, e, w;

        // Reset state.
        step(3);
        chk("reset_sel", int'(rec_data_sel), 0);
        chk("reset_mc",  int'(mode_change), 0);
        chk("reset_fs",  int'(failsafe_active), 0);
        resetn = 1'b1;
        step(D + 10);

        // Auto takeoff: TAKEOFF after debounce, HOVER exactly T cycles later.
        n = cyc;
        swa = 1'b1; swb = 2'd1;
        push(1, 0, n + D + 1, "takeoff");
        push(2, 0, n + D + 1 + T, "hover");
        step_to(n + D + 1 + T + 5);

        // Landing with a motor glitch that restarts the landed count.
        n = cyc;
        swb = 2'd2;
        e = n + D + 1;
        push(4, 0, e, "land");
        push(0, 0, e + 101 + L, "landed");
        step_to(e + 100);
        rate = PW'(50);
        step(1);
        rate = '0;
        step_to(e + 101 + L + D);
        chk("no_relaunch_sel", int'(rec_data_sel), 0);

        // Arming with high throttle is refused until the arm switch is cycled.
        swa = 1'b0; swb = 2'd0; thr = PW'(200);
        step(D + 5);
        swa = 1'b1;
        step(D + 20);
        chk("high_thr_refused", int'(rec_data_sel), 0);
        thr = PW'(5);
        step(50);
        chk("low_thr_needs_rearm", int'(rec_data_sel), 0);
        swa = 1'b0;
        step(D + 5);
        n = cyc;
        swa = 1'b1;
        push(3, 0, n + D + 1, "pass_through");
        step(D + 10);

        // Kill from pass-through.
        n = cyc;
        swa = 1'b0;
        push(0, 0, n + D + 1, "kill");
        step(D + 10);

        // Disarm in hover lands instead of killing; disarm ignored while landing.
        n = cyc;
        swa = 1'b1; swb = 2'd1;
        push(1, 0, n + D + 1, "takeoff2");
        push(2, 0, n + D + 1 + T, "hover2");
        step_to(n + D + 1 + T + 5);
        n = cyc;
        swa = 1'b0;
        push(4, 0, n + D + 1, "disarm_land");
        push(0, 0, n + D + 1 + L, "disarm_landed");
        step(D + L + 10);

        // Switch glitch shorter than the debounce window, then reset mid-flight.
        n = cyc;
        swa = 1'b1;
        push(1, 0, n + D + 1, "takeoff3");
        push(2, 0, n + D + 1 + T, "hover3");
        step_to(n + D + 1 + T + 5);
        swb = 2'd0;
        step(100);
        swb = 2'd1;
        step(D + 20);
        chk("glitch_ignored", int'(rec_data_sel), 2);
        resetn = 1'b0;
        step(1);
        chk("midflight_reset_sel", int'(rec_data_sel), 0);
        chk("midflight_reset_mc",  int'(mode_change), 0);
        resetn = 1'b1; swa = 1'b0; swb = 2'd0;
        step(D + 10);
        chk("after_reset_sel", int'(rec_data_sel), 0);

        // Link loss in pass-through.
        n = cyc;
        thr = PW'(5); swa = 1'b1;
        push(3, 0, n + D + 1, "pt_fs");
        step(D + 10);
        n = cyc;
        rec_valid = 1'b0;
`ifdef FLIGHT_MODE_FAILSAFE_EN
        push(4, 1, n + F, "failsafe_land");
        push(0, 1, n + F + L, "failsafe_landed");
        step(F + L + 10);
        chk("failsafe_held", int'(failsafe_active), 1);
        rec_valid = 1'b1;
        step(2);
        chk("failsafe_clear", int'(failsafe_active), 0);
        chk("failsafe_end_sel", int'(rec_data_sel), 0);
`else
        step(F + L + 10);
        chk("nofs_sel", int'(rec_data_sel), 3);
        chk("nofs_flag", int'(failsafe_active), 0);
        rec_valid = 1'b1;
`endif

        // Drain scoreboard with a bounded wait.
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            step(1);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_changes: got %0d outstanding expected 0 (next %s)",
                     sb.size(), sb[0].tag);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
